// File: rtl/ifu_imem_reader.sv
// Instruction-memory read master for the IFU: fetches 128b lines from i_mem and
// hands them to decode one instruction at a time over a valid/ready handshake.
module ifu_imem_reader #(
    parameter int                    DATA_WIDTH  = 128,
    parameter int                    ADRS_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADRS_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [ADRS_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADRS_WIDTH-1:0]  instr_pc,
    output logic [ADRS_WIDTH-1:0]  mem_address,
    output logic                   mem_wren,
    output logic [DATA_WIDTH-1:0]  mem_data,
    input  logic [DATA_WIDTH-1:0]  mem_q
);

    localparam int WPL    = DATA_WIDTH / INSTR_WIDTH;
    localparam int OFS    = $clog2(DATA_WIDTH / 8);
    localparam int WSEL_W = $clog2(WPL);

    localparam logic [ADRS_WIDTH-1:0] PC_MASK = ~ADRS_WIDTH'(3);
    localparam logic [ADRS_WIDTH-1:0] PC_INIT = RESET_PC & PC_MASK;
    localparam logic [ADRS_WIDTH-1:0] PC_STEP = ADRS_WIDTH'(4);
    localparam logic [WSEL_W-1:0]     LAST_W  = WSEL_W'(WPL - 1);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_SERVE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADRS_WIDTH-1:0]   pc;
    logic [ADRS_WIDTH-1:0]   pc_nxt;
    logic [DATA_WIDTH-1:0]   line_buf;
    logic [WSEL_W-1:0]       word_sel;
    logic [INSTR_WIDTH-1:0]  words [WPL];
    logic                    fire;
    logic                    last_word;

    // Unpacked view of the buffered line so word selection is a plain array index.
    for (genvar k = 0; k < WPL; k++) begin : g_words
        assign words[k] = line_buf[k*INSTR_WIDTH +: INSTR_WIDTH];
    end

    assign word_sel    = pc[2 +: WSEL_W];
    assign last_word   = (word_sel == LAST_W);
    assign instr_valid = (state == S_SERVE);
    assign instr       = words[word_sel];
    assign instr_pc    = pc;
    assign fire        = instr_valid & instr_ready;

    // i_mem is read-only from this port.
    assign mem_wren = 1'b0;
    assign mem_data = '0;

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        if (redirect_valid) begin
            // Redirect beats a same-cycle fire: that instruction is consumed, its pc+4 is dropped.
            pc_nxt    = redirect_pc & PC_MASK;
            state_nxt = S_REQ;
        end else begin
            unique case (state)
                S_REQ:   state_nxt = S_WAIT;
                S_WAIT:  state_nxt = S_SERVE;
                S_SERVE: begin
                    if (fire) begin
                        pc_nxt = pc + PC_STEP;
                        if (last_word) begin
                            state_nxt = S_REQ;
                        end
                    end
                end
                default: state_nxt = S_REQ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of process ordering.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
            pc    <= PC_INIT;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Line address is launched from S_REQ; the memory answers before the S_WAIT edge.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            mem_address <= RESET_PC >> OFS;
        end else if (state == S_REQ) begin
            mem_address <= pc >> OFS;
        end
    end

    // NOTE: the line buffer is reset so instr reads as zero out of reset; a
    // redirect during S_WAIT discards the in-flight line instead of capturing it.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            line_buf <= '0;
        end else if (state == S_WAIT && !redirect_valid) begin
            line_buf <= mem_q;
        end
    end

endmodule

// File: tb/tb_ifu_imem_reader.sv
// Bench for ifu_imem_reader: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a fetch-level reference model.
module tb_ifu_imem_reader;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_pc    = '0;
    logic         instr_valid;
    logic         instr_ready    = 1'b0;
    logic [31:0]  instr;
    logic [31:0]  instr_pc;
    logic [31:0]  mem_address;
    logic         mem_wren;
    logic [127:0] mem_data;
    logic [127:0] mem_q;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    ifu_imem_reader #(
        .DATA_WIDTH (128),
        .ADRS_WIDTH (32),
        .INSTR_WIDTH(32),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clock         (clock),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .mem_address   (mem_address),
        .mem_wren      (mem_wren),
        .mem_data      (mem_data),
        .mem_q         (mem_q)
    );

    // Memory contents: word k of line L. Line 0 holds 1,2,3,4.
    function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
        return {line[7:0], 24'h0} ^ (line * 32'd4 + 32'(k) + 32'd1);
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] line);
        return {mem_word(line, 3), mem_word(line, 2), mem_word(line, 1), mem_word(line, 0)};
    endfunction

    assign mem_q = mem_line(mem_address);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Reference model: fetch pc, whether an instruction is presented, and the
    // number of edges still needed before a refetched line is presented.
    logic [31:0] m_pc;
    logic        m_valid;
    int          m_wait;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            m_pc    = RESET_PC & ~32'd3;
            m_valid = 1'b0;
            m_wait  = 2;
        end else if (redirect_valid) begin
            m_pc    = redirect_pc & ~32'd3;
            m_valid = 1'b0;
            m_wait  = 2;
        end else if (m_valid) begin
            if (instr_ready) begin
                if (m_pc[3:2] == 2'd3) begin
                    m_valid = 1'b0;
                    m_wait  = 2;
                end
                m_pc = m_pc + 32'd4;
            end
        end else begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end
    end

    always @(negedge clock) begin
        if (!rst) begin
            check("m_valid", instr_valid, m_valid);
            check("m_wren", mem_wren, 1'b0);
            check("m_data", mem_data, 128'h0);
            if (m_valid) begin
                check("m_instr", instr, mem_word(m_pc >> 4, int'(m_pc[3:2])));
                check("m_instr_pc", instr_pc, m_pc);
                check("m_mem_address", mem_address, m_pc >> 4);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic redirect(input logic [31:0] addr);
        redirect_valid = 1'b1;
        redirect_pc    = addr;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid", instr_valid, 1'b1);
    endtask

    initial begin
        #100000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_wren", mem_wren, 1'b0);

        // Line 0 streams out, then line 1 is fetched
        tick();
        rst = 1'b0;
        instr_ready = 1'b1;
        tick();
        check("t1_wait_valid", instr_valid, 1'b0);
        check("t1_mem_address0", mem_address, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_valid", instr_valid, 1'b1);
            check("t1_instr", instr, 32'(i + 1));
            check("t1_instr_pc", instr_pc, 32'(4 * i));
        end
        tick();
        check("t1_gap1", instr_valid, 1'b0);
        tick();
        check("t1_gap2", instr_valid, 1'b0);
        check("t1_mem_address1", mem_address, 32'h1);
        tick();
        check("t1_line1_valid", instr_valid, 1'b1);
        check("t1_line1_pc", instr_pc, 32'h10);
        check("t1_line1_instr", instr, 32'h0100_0005);

        // Backpressure on pc 4
        redirect(32'h0);
        check("t2_redir_valid", instr_valid, 1'b0);
        wait_valid(4);
        tick();
        check("t2_pc4", instr_pc, 32'h4);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_valid", instr_valid, 1'b1);
            check("t2_hold_instr", instr, 32'h2);
            check("t2_hold_pc", instr_pc, 32'h4);
        end
        instr_ready = 1'b1;
        tick();
        check("t2_next_pc", instr_pc, 32'h8);
        check("t2_next_instr", instr, 32'h3);

        // Fire at pc 8 and redirect to 0x40 in the same cycle
        redirect(32'h40);
        check("t4_valid_low", instr_valid, 1'b0);
        tick();
        check("t4_mem_address", mem_address, 32'h4);
        tick();
        check("t4_pc", instr_pc, 32'h40);
        check("t4_instr", instr, 32'h0400_0011);

        // Redirect to 0x26 while serving pc 4
        redirect(32'h4);
        wait_valid(4);
        check("t3_pc4", instr_pc, 32'h4);
        redirect(32'h26);
        check("t3_valid_low", instr_valid, 1'b0);
        tick();
        check("t3_mem_address", mem_address, 32'h2);
        tick();
        check("t3_valid", instr_valid, 1'b1);
        check("t3_pc", instr_pc, 32'h24);
        check("t3_instr", instr, 32'h0200_000A);

        // Wrap at the top of the address space
        instr_ready = 1'b0;
        redirect(32'hFFFF_FFFC);
        tick();
        check("t6_mem_address", mem_address, 32'h0FFF_FFFF);
        tick();
        check("t6_pc", instr_pc, 32'hFFFF_FFFC);
        instr_ready = 1'b1;
        tick();
        check("t6_refetch", instr_valid, 1'b0);
        tick();
        check("t6_mem_address0", mem_address, 32'h0);
        tick();
        check("t6_wrap_pc", instr_pc, 32'h0);
        check("t6_wrap_instr", instr, 32'h1);

        // Asynchronous reset between edges while serving
        tick();
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", instr_valid, 1'b0);
        check("t5_async_pc", instr_pc, RESET_PC);
        tick();
        rst = 1'b0;
        tick();
        check("t5_mem_address", mem_address, RESET_PC >> 4);
        tick();
        check("t5_valid", instr_valid, 1'b1);
        check("t5_pc", instr_pc, RESET_PC);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = $urandom & 32'h0000_00FF;
                default: redirect_pc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            endcase
        end
        redirect_valid = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
